// File: rtl/bp_resolve_pkg.sv
// bp_resolve_pkg: shared constants and types for branch resolution
package bp_resolve_pkg;
   localparam int BP_QUEUE_DEPTH = 4;
   typedef enum logic [1:0] {
      BP_UPD_NONE = 2'b00,
      BP_UPD_NT   = 2'b01,
      BP_UPD_T    = 2'b10
   } bp_upd_e;
   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } pred_entry_t;
endpackage

// File: rtl/bp_pred_fifo.sv
// bp_pred_fifo: in-order prediction queue with push, pop, clear and head read
module bp_pred_fifo
   import bp_resolve_pkg::*;
#(
   parameter int DEPTH = BP_QUEUE_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic        clear_i,
   input  pred_entry_t din_i,
   output pred_entry_t head_o,
   output logic [PTR_W:0] count_o,
   output logic        full_o,
   output logic        empty_o
);
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0] cnt_q, cnt_d;
   pred_entry_t mem_q [DEPTH];
   pred_entry_t mem_d [DEPTH];
   logic do_push, do_pop;
   assign full_o  = cnt_q == (PTR_W+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   // clear wins over a same-cycle push so wrong-path predictions never land
   always_comb begin
      do_push = push_i && !full_o;
      do_pop = pop_i && !empty_o;
      mem_d = mem_q;
      wr_d = wr_q;
      rd_d = rd_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         wr_d = '0;
         rd_d = '0;
         cnt_d = '0;
      end else begin
         if (do_push) mem_d[wr_q] = din_i;
         wr_d = do_push ? wr_q + 1'b1 : wr_q;
         rd_d = do_pop ? rd_q + 1'b1 : rd_q;
         cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         mem_q <= '{default: '0};
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end
endmodule

// File: rtl/bp_resolve.sv
// bp_resolve: checks EX branch outcomes against queued IF predictions,
// redirects fetch on mispredict, trains the predictor and counts events.
module bp_resolve
   import bp_resolve_pkg::*;
#(
   parameter int DEPTH = BP_QUEUE_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pred_valid_i,
   input  logic [31:0]   pred_pc_i,
   input  logic          pred_taken_i,
   input  logic [31:0]   pred_target_i,
   output logic          pred_ready_o,
   input  logic          res_valid_i,
   input  logic          res_is_cond_i,
   input  logic [31:0]   res_pc_i,
   input  logic          res_taken_i,
   input  logic [31:0]   res_target_i,
   input  logic          flush_i,
   output logic [1:0]    branch_taken_o,
   output logic          redirect_o,
   output logic [31:0]   redirect_addr_o,
   output logic [31:0]   br_cnt_o,
   output logic [31:0]   mispred_cnt_o,
   output logic [PTR_W:0] q_count_o
);
   pred_entry_t head, entry;
   logic full, empty, hit, p_taken, mispred;
   logic [31:0] p_target, br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   bp_upd_e upd_q, upd_d;
   assign entry = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};
   assign pred_ready_o = !full;
   bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pred_valid_i && !full),
      .pop_i   (res_valid_i),
      .clear_i (flush_i || mispred),
      .din_i   (entry),
      .head_o  (head),
      .count_o (q_count_o),
      .full_o  (full),
      .empty_o (empty)
   );
   // an unmatched resolution is treated as predicted not-taken with target 0
   always_comb begin
      hit = !empty && head.pc == res_pc_i;
      p_taken = hit && head.taken;
      p_target = hit ? head.target : '0;
      mispred = res_valid_i && (p_taken != res_taken_i || (p_taken && res_taken_i && p_target != res_target_i));
      redirect_o = mispred;
      redirect_addr_o = !mispred ? '0 : res_taken_i ? res_target_i : res_pc_i + 32'd4;
      upd_d = !(res_valid_i && res_is_cond_i) ? BP_UPD_NONE : res_taken_i ? BP_UPD_T : BP_UPD_NT;
      br_cnt_d = br_cnt_q + {31'd0, res_valid_i && res_is_cond_i};
      mis_cnt_d = mis_cnt_q + {31'd0, mispred};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_q <= BP_UPD_NONE;
         br_cnt_q <= '0;
         mis_cnt_q <= '0;
      end else begin
         upd_q <= upd_d;
         br_cnt_q <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end
   assign branch_taken_o = upd_q;
   assign br_cnt_o = br_cnt_q;
   assign mispred_cnt_o = mis_cnt_q;
endmodule

// File: doc/bp_resolve.md
Name: bp_resolve

Overview:
- Resolution end of the branch-prediction loop; sits beside EX.
- Records every IF-stage prediction in a small in-order queue.
- When EX resolves a branch or jal, compares the actual outcome with the oldest queued prediction.
- Drives the 2-bit taken/not-taken training code back to the predictor, raises a redirect on mispredict, and keeps branch/mispredict counters.

Parameters:
DEPTH, 4, prediction queue entries (power of 2, >=2)
PTR_W, $clog2(DEPTH), queue pointer width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pred_valid_i  in  1  IF issued a branch/jal prediction this cycle
pred_pc_i  in  32  address of predicted instruction
pred_taken_i  in  1  predicted taken
pred_target_i  in  32  predicted target
pred_ready_o  out  1  queue not full; push is ignored when low
res_valid_i  in  1  EX resolved a branch/jal this cycle
res_is_cond_i  in  1  1 = conditional B-type, 0 = jal
res_pc_i  in  32  address of resolved instruction
res_taken_i  in  1  actual taken
res_target_i  in  32  actual taken target
flush_i  in  1  external pipeline flush (trap/interrupt)
branch_taken_o  out  2  predictor training: 00 none, 01 not taken, 10 taken
redirect_o  out  1  mispredict; fetch must restart at redirect_addr_o
redirect_addr_o  out  32  corrected fetch address
br_cnt_o  out  32  resolved conditional branches
mispred_cnt_o  out  32  mispredicts (all types)
q_count_o  out  PTR_W+1  queue occupancy (debug)

Behaviour:
- Reset values: queue empty, branch_taken_o=00, redirect_o=0, redirect_addr_o=0, both counters 0, pred_ready_o=1.
- Queue: circular FIFO; entry = {pc, taken, target}. Push when pred_valid_i && pred_ready_o. Pop when res_valid_i && not empty. pred_ready_o = (count != DEPTH). It is not relaxed by a same-cycle pop.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Match: head valid && head.pc == res_pc_i. Otherwise the instruction is an orphan: predicted = not taken, target = 0. Head is still popped if present.
- Mispredict (combinational, same cycle as res_valid_i): pred_taken != res_taken_i, or both taken && pred_target != res_target_i.
- redirect_o / redirect_addr_o are combinational and valid only in the res_valid_i cycle.
  - redirect_addr_o = res_target_i if res_taken_i, else res_pc_i + 4 (32-bit wrap).
  - redirect_addr_o is 0 when redirect_o = 0.
- On mispredict, at the next edge the whole queue is cleared (younger entries are wrong-path). Any same-cycle push is dropped.
- flush_i: queue cleared at the edge, same-cycle push dropped. Resolution in the same cycle is still evaluated and its outputs still produced. If flush_i and mispredict occur together, the queue is cleared once.
- branch_taken_o: registered, 1-cycle latency, one-cycle pulse.
  - Set to 10 or 01 the cycle after res_valid_i && res_is_cond_i, per res_taken_i.
  - 00 otherwise; jal never trains.
- Counters: br_cnt_o increments on each res_valid_i && res_is_cond_i. mispred_cnt_o increments on each mispredict. Both wrap at 2^32, registered (+1 cycle).
- rst mid-operation: all state returns to reset values at the edge, regardless of other inputs.

Decomposition:
- defines.v gains BP_UPD_NONE 2'b00, BP_UPD_NT 2'b01, BP_UPD_T 2'b10, and BP_QUEUE_DEPTH.
- One sub-module, bp_pred_fifo: parameterised FIFO with push/pop/clear, head read, count.
- bp_resolve holds the compare, redirect, training and counter logic.

Test Plan:
- Push {0x100, T, 0x140}; resolve 0x100 taken 0x140 cond -> redirect_o=0; next cycle branch_taken_o=10, br_cnt_o=1, queue empty.
- Push {0x200, NT}, {0x204, T, 0x300}; resolve 0x200 taken 0x280 -> redirect_o=1, addr 0x280; next cycle queue empty, mispred_cnt_o=1, branch_taken_o=10.
- Push {0x300, T, 0x400}; resolve 0x300 not taken -> redirect addr 0x304; next cycle branch_taken_o=01.
- Push 4 entries -> pred_ready_o=0; 5th push ignored; push+pop in one cycle at count 3 -> count stays 3.
- Resolve jal 0x500 target 0x600 with empty queue -> orphan: redirect_o=1, addr 0x600; branch_taken_o stays 00; mispred_cnt_o increments.
- Queue holds 2 entries; assert flush_i with pred_valid_i -> queue empty next cycle, push dropped. Assert rst with res_valid_i -> all outputs at reset values next cycle.
